// File: rtl/bus_capture_fifo_pkg.sv
// bus_capture_fifo_pkg: shared bus width and capture FIFO depth defaults
package bus_capture_fifo_pkg;
  localparam int BUS_WIDTH = 8;
  localparam int CAPFIFO_DEPTH = 4;
endpackage

// File: rtl/bus_capture_fifo_mem.sv
// bus_capture_fifo_mem: DEPTH x WIDTH register array, one write port, async read
module bus_capture_fifo_mem #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int AW = 2
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);
  logic [WIDTH-1:0] mem [DEPTH];
  // storage is deliberately unreset; VALID qualifies every read
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/bus_capture_fifo.sv
// bus_capture_fifo: captures one byte per tri-state bus enable window into a FIFO
module bus_capture_fifo
  import bus_capture_fifo_pkg::*;
#(
  parameter int WIDTH = BUS_WIDTH,
  parameter int DEPTH = CAPFIFO_DEPTH,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] bus,
  input  logic             oenb_n,
  input  logic             cap_en,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             valid,
  output logic             full,
  output logic [AW:0]      count,
  output logic             ovf,
  input  logic             clr_ovf
);
  logic          oe_q;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          push, pop_en, wr_en, drop;
  // push only on the first edge of a low window; a full FIFO accepts it only alongside a pop
  always_comb begin
    push   = cap_en & ~oenb_n & oe_q;
    pop_en = pop & valid;
    wr_en  = push & (~full | pop_en);
    drop   = push & full & ~pop_en;
  end
  assign valid = count != '0;
  assign full  = count == (AW+1)'(DEPTH);
  // window tracking, pointers, occupancy and sticky overflow
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      oe_q   <= 1'b1;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
    end else begin
      oe_q <= oenb_n;
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (pop_en) rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(wr_en) - (AW+1)'(pop_en);
      ovf   <= drop | (ovf & ~clr_ovf);
    end
  bus_capture_fifo_mem #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) u_mem (
    .clk  (clk),
    .we   (wr_en),
    .waddr(wr_ptr),
    .wdata(bus),
    .raddr(rd_ptr),
    .rdata(dout)
  );
endmodule

// File: tb/tb_bus_capture_fifo.sv
// tb_bus_capture_fifo: directed checks of window capture, FIFO order, overflow and reset
module tb_bus_capture_fifo;
  logic       clk = 0, rst = 1, oenb_n = 1, cap_en = 1, pop = 0, clr_ovf = 0;
  logic [7:0] bus = 8'h00;
  logic [7:0] dout;
  logic       valid, full, ovf;
  logic [2:0] count;
  int n_tests = 0, n_fail = 0;

  bus_capture_fifo dut (
    .clk(clk), .rst(rst), .bus(bus), .oenb_n(oenb_n), .cap_en(cap_en), .pop(pop),
    .dout(dout), .valid(valid), .full(full), .count(count), .ovf(ovf), .clr_ovf(clr_ovf)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic window(input logic [7:0] d);
    bus = d; oenb_n = 0;
    cyc();
    oenb_n = 1;
    cyc();
  endtask

  task automatic pop_check(input logic [7:0] exp, input string name);
    n_tests++;
    if (dout !== exp || valid !== 1'b1) begin
      n_fail++;
      $display("FAIL %s: dout=%h valid=%b want dout=%h valid=1", name, dout, valid, exp);
    end
    pop = 1; cyc(); pop = 0;
  endtask

  task automatic test_reset();
    rst = 1; #2;
    n_tests++;
    if (count !== 3'd0 || valid !== 0 || full !== 0 || ovf !== 0) begin
      n_fail++; $display("FAIL reset_init: count=%0d valid=%b full=%b ovf=%b want 0 0 0 0", count, valid, full, ovf);
    end
    cyc(); rst = 0; cyc();
    window(8'h11); window(8'h22); window(8'h33);
    n_tests++;
    if (count !== 3'd3) begin n_fail++; $display("FAIL reset_fill: count=%0d want 3", count); end
    #2 rst = 1; #1;
    n_tests++;
    if (count !== 3'd0 || valid !== 0 || ovf !== 0) begin
      n_fail++; $display("FAIL reset_async: count=%0d valid=%b ovf=%b want 0 0 0", count, valid, ovf);
    end
    cyc(); rst = 0; cyc();
    n_tests++;
    if (count !== 3'd0) begin n_fail++; $display("FAIL reset_release: count=%0d want 0", count); end
  endtask

  task automatic test_single_window();
    bus = 8'hA5; oenb_n = 0;
    cyc();
    n_tests++;
    if (count !== 3'd1 || dout !== 8'hA5 || valid !== 1) begin
      n_fail++; $display("FAIL single_first: count=%0d dout=%h valid=%b want 1 a5 1", count, dout, valid);
    end
    repeat (4) cyc();
    oenb_n = 1; cyc();
    n_tests++;
    if (count !== 3'd1) begin n_fail++; $display("FAIL single_once: count=%0d want 1", count); end
    pop_check(8'hA5, "single_pop");
    n_tests++;
    if (count !== 3'd0 || valid !== 0) begin n_fail++; $display("FAIL single_empty: count=%0d valid=%b want 0 0", count, valid); end
  endtask

  task automatic test_overflow();
    window(8'h01); window(8'h02); window(8'h03);
    n_tests++;
    if (full !== 0) begin n_fail++; $display("FAIL ovf_notfull: full=%b want 0", full); end
    window(8'h04);
    n_tests++;
    if (full !== 1 || count !== 3'd4 || ovf !== 0) begin
      n_fail++; $display("FAIL ovf_full: full=%b count=%0d ovf=%b want 1 4 0", full, count, ovf);
    end
    window(8'h05);
    n_tests++;
    if (ovf !== 1 || count !== 3'd4) begin n_fail++; $display("FAIL ovf_drop: ovf=%b count=%0d want 1 4", ovf, count); end
    pop_check(8'h01, "ovf_pop1"); pop_check(8'h02, "ovf_pop2");
    pop_check(8'h03, "ovf_pop3"); pop_check(8'h04, "ovf_pop4");
    n_tests++;
    if (count !== 3'd0 || ovf !== 1) begin n_fail++; $display("FAIL ovf_sticky: count=%0d ovf=%b want 0 1", count, ovf); end
    clr_ovf = 1; cyc(); clr_ovf = 0;
    n_tests++;
    if (ovf !== 0) begin n_fail++; $display("FAIL ovf_clear: ovf=%b want 0", ovf); end
  endtask

  task automatic test_full_push_pop();
    window(8'h10); window(8'h11); window(8'h12); window(8'h13);
    bus = 8'h77; oenb_n = 0; pop = 1;
    cyc();
    pop = 0; oenb_n = 1; cyc();
    n_tests++;
    if (count !== 3'd4 || ovf !== 0 || full !== 1) begin
      n_fail++; $display("FAIL fullpp: count=%0d ovf=%b full=%b want 4 0 1", count, ovf, full);
    end
    pop_check(8'h11, "fullpp_pop1"); pop_check(8'h12, "fullpp_pop2");
    pop_check(8'h13, "fullpp_pop3"); pop_check(8'h77, "fullpp_pop4");
  endtask

  task automatic test_empty_pop();
    pop = 1; repeat (3) cyc(); pop = 0;
    n_tests++;
    if (count !== 3'd0 || valid !== 0) begin n_fail++; $display("FAIL empty_pop: count=%0d valid=%b want 0 0", count, valid); end
    window(8'h3C);
    n_tests++;
    if (valid !== 1 || dout !== 8'h3C || count !== 3'd1) begin
      n_fail++; $display("FAIL empty_then_push: valid=%b dout=%h count=%0d want 1 3c 1", valid, dout, count);
    end
    pop = 1; cyc(); pop = 0;
    bus = 8'h9E; oenb_n = 0; pop = 1; cyc(); pop = 0; oenb_n = 1; cyc();
    n_tests++;
    if (count !== 3'd1 || dout !== 8'h9E) begin
      n_fail++; $display("FAIL empty_push_pop: count=%0d dout=%h want 1 9e", count, dout);
    end
    pop = 1; cyc(); pop = 0;
  endtask

  task automatic test_cap_en();
    cap_en = 0; bus = 8'hEE; oenb_n = 0;
    repeat (2) cyc();
    cap_en = 1;
    repeat (2) cyc();
    oenb_n = 1; cyc();
    n_tests++;
    if (count !== 3'd0) begin n_fail++; $display("FAIL capen_mid: count=%0d want 0", count); end
    window(8'h5A);
    n_tests++;
    if (count !== 3'd1 || dout !== 8'h5A) begin n_fail++; $display("FAIL capen_next: count=%0d dout=%h want 1 5a", count, dout); end
    window(8'h5B); window(8'h5C); window(8'h5D); window(8'h5E);
    n_tests++;
    if (ovf !== 1) begin n_fail++; $display("FAIL clr_pre: ovf=%b want 1", ovf); end
    bus = 8'h5F; oenb_n = 0; clr_ovf = 1; cyc(); clr_ovf = 0; oenb_n = 1; cyc();
    n_tests++;
    if (ovf !== 1 || count !== 3'd4) begin n_fail++; $display("FAIL clr_collide: ovf=%b count=%0d want 1 4", ovf, count); end
    clr_ovf = 1; cyc(); clr_ovf = 0;
    n_tests++;
    if (ovf !== 0) begin n_fail++; $display("FAIL clr_after: ovf=%b want 0", ovf); end
    pop_check(8'h5A, "capen_pop1");
  endtask

  initial begin
    test_reset();
    test_single_window();
    test_overflow();
    test_full_push_pop();
    test_empty_pop();
    test_cap_en();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
